// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// resolves EX/MEM and MEM/WB forwarding, and inserts a bubble on a load-use hazard.
module id_ex_operand_stage #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  REG_ADDR_W = 5,
  parameter int                  OP_WIDTH   = 4,
  parameter logic [OP_WIDTH-1:0] NOP_OP     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [OP_WIDTH-1:0]   alu_op_i,
  input  logic                  alu_src_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0] exmem_data_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0] memwb_data_i,
  output logic [OP_WIDTH-1:0]   alu_operation_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  valid_o,
  output logic                  hazard_o
);

  logic                  r_valid;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic                  r_alu_src;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic [REG_ADDR_W-1:0] r_rs_addr;
  logic [REG_ADDR_W-1:0] r_rt_addr;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [DATA_WIDTH-1:0] r_rt_data;
  logic [DATA_WIDTH-1:0] r_imm;

  logic                  w_hazard;
  logic [DATA_WIDTH-1:0] w_fwd_rs;
  logic [DATA_WIDTH-1:0] w_fwd_rt;

  // Youngest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_WIDTH-1:0] reg_data,
    input logic                  xm_we,
    input logic [REG_ADDR_W-1:0] xm_rd,
    input logic [DATA_WIDTH-1:0] xm_data,
    input logic                  mw_we,
    input logic [REG_ADDR_W-1:0] mw_rd,
    input logic [DATA_WIDTH-1:0] mw_data
  );
    if (xm_we && (xm_rd != '0) && (xm_rd == src))
      return xm_data;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src))
      return mw_data;
    else
      return reg_data;
  endfunction

  // rt only matters for the hazard when it is actually read as operand B.
  assign w_hazard = r_valid && r_mem_read && (r_rd != '0) && valid_i &&
                    ((rs_addr_i == r_rd) || ((rt_addr_i == r_rd) && !alu_src_i));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_alu_op    <= NOP_OP;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
    end else if (flush_i || w_hazard) begin
      // Bubble overrides stall so the stalled load can advance.
      r_valid     <= 1'b0;
      r_alu_op    <= NOP_OP;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
    end else if (!stall_i) begin
      r_valid     <= valid_i;
      r_alu_op    <= alu_op_i;
      r_alu_src   <= alu_src_i;
      r_reg_write <= reg_write_i && valid_i;
      r_mem_read  <= mem_read_i && valid_i;
      r_rs_addr   <= rs_addr_i;
      r_rt_addr   <= rt_addr_i;
      r_rd        <= rd_addr_i;
      r_rs_data   <= rs_data_i;
      r_rt_data   <= rt_data_i;
      r_imm       <= imm_i;
    end
  end

  // Operand stage boundary: forwarding on registered source addresses.
  always_comb begin
    w_fwd_rs = fwd_sel(r_rs_addr, r_rs_data, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                       memwb_reg_write_i, memwb_rd_i, memwb_data_i);
    w_fwd_rt = fwd_sel(r_rt_addr, r_rt_data, exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                       memwb_reg_write_i, memwb_rd_i, memwb_data_i);
  end

  assign a_o             = w_fwd_rs;
  assign b_o             = r_alu_src ? r_imm : w_fwd_rt;
  assign store_data_o    = w_fwd_rt;
  assign alu_operation_o = r_alu_op;
  assign rd_o            = r_rd;
  assign reg_write_o     = r_reg_write;
  assign mem_read_o      = r_mem_read;
  assign valid_o         = r_valid;
  assign hazard_o        = w_hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Table-driven bench for id_ex_operand_stage with an expected-result queue.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, valid_i;
  logic [3:0]  alu_op_i;
  logic        alu_src_i, reg_write_i, mem_read_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_data_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [3:0]  alu_operation_o;
  logic [31:0] a_o, b_o, store_data_o;
  logic [4:0]  rd_o;
  logic        reg_write_o, mem_read_o, valid_o, hazard_o;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .exmem_data_i(exmem_data_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_operation_o(alu_operation_o), .a_o(a_o), .b_o(b_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .valid_o(valid_o),
    .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, st;
    logic [4:0]  rd;
    logic        rw, mr, vl, hz;
  } exp_t;

  typedef struct {
    logic        fl, stl, vl;
    logic [3:0]  op;
    logic        src, rw, mr;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];

  function automatic vec_t mkv(logic fl, logic stl, logic vl, logic [3:0] op, logic src,
                               logic rw, logic mr, logic [4:0] rs, logic [4:0] rt,
                               logic [4:0] rd, logic [31:0] rsd, logic [31:0] rtd,
                               logic [31:0] imm);
    vec_t v;
    v.fl = fl; v.stl = stl; v.vl = vl; v.op = op; v.src = src; v.rw = rw; v.mr = mr;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd; v.imm = imm;
    v.xw = 1'b0; v.xrd = '0; v.xd = '0; v.ww = 1'b0; v.wrd = '0; v.wd = '0;
    v.e = '{op: 4'h0, a: 32'h0, b: 32'h0, st: 32'h0, rd: 5'h0, rw: 1'b0, mr: 1'b0,
            vl: 1'b0, hz: 1'b0};
    return v;
  endfunction

  function automatic vec_t fw(vec_t v, logic xw, logic [4:0] xrd, logic [31:0] xd,
                              logic ww, logic [4:0] wrd, logic [31:0] wd);
    vec_t r = v;
    r.xw = xw; r.xrd = xrd; r.xd = xd; r.ww = ww; r.wrd = wrd; r.wd = wd;
    return r;
  endfunction

  function automatic vec_t ex(vec_t v, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] st, logic [4:0] rd, logic rw, logic mr,
                              logic vl, logic hz);
    vec_t r = v;
    r.e = '{op: op, a: a, b: b, st: st, rd: rd, rw: rw, mr: mr, vl: vl, hz: hz};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    flush_i = v.fl; stall_i = v.stl; valid_i = v.vl; alu_op_i = v.op; alu_src_i = v.src;
    reg_write_i = v.rw; mem_read_i = v.mr; rs_addr_i = v.rs; rt_addr_i = v.rt;
    rd_addr_i = v.rd; rs_data_i = v.rsd; rt_data_i = v.rtd; imm_i = v.imm;
    exmem_reg_write_i = v.xw; exmem_rd_i = v.xrd; exmem_data_i = v.xd;
    memwb_reg_write_i = v.ww; memwb_rd_i = v.wrd; memwb_data_i = v.wd;
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v.e);
    #1;
    chk({nm, ".hazard"}, {31'b0, hazard_o}, {31'b0, v.e.hz});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({nm, ".op"},    {28'b0, alu_operation_o}, {28'b0, e.op});
    chk({nm, ".a"},     a_o, e.a);
    chk({nm, ".b"},     b_o, e.b);
    chk({nm, ".store"}, store_data_o, e.st);
    chk({nm, ".rd"},    {27'b0, rd_o}, {27'b0, e.rd});
    chk({nm, ".rw"},    {31'b0, reg_write_o}, {31'b0, e.rw});
    chk({nm, ".mr"},    {31'b0, mem_read_o}, {31'b0, e.mr});
    chk({nm, ".valid"}, {31'b0, valid_o}, {31'b0, e.vl});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, {31'b0, valid_o}, 32'h0);
    chk({nm, ".op"},    {28'b0, alu_operation_o}, 32'h0);
    chk({nm, ".a"},     a_o, 32'h0);
    chk({nm, ".b"},     b_o, 32'h0);
    chk({nm, ".store"}, store_data_o, 32'h0);
    chk({nm, ".rd"},    {27'b0, rd_o}, 32'h0);
    chk({nm, ".rw"},    {31'b0, reg_write_o}, 32'h0);
    chk({nm, ".mr"},    {31'b0, mem_read_o}, 32'h0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = ex(mkv(0,0,1,4'h3,0,1,0, 5'd1,5'd2,5'd3, 32'd5,32'd7,32'd0),
                 4'h3, 32'd5, 32'd7, 32'd7, 5'd3, 1,0,1,0);
    tbl[1]  = ex(fw(mkv(0,0,1,4'h2,0,1,0, 5'd1,5'd2,5'd6, 32'hAA,32'hBB,32'd0),
                    1,5'd1,32'h10, 1,5'd1,32'h20),
                 4'h2, 32'h10, 32'hBB, 32'hBB, 5'd6, 1,0,1,0);
    tbl[2]  = ex(fw(mkv(0,0,1,4'h2,0,1,0, 5'd1,5'd2,5'd6, 32'hAA,32'hBB,32'd0),
                    1,5'd0,32'h10, 1,5'd1,32'h20),
                 4'h2, 32'h20, 32'hBB, 32'hBB, 5'd6, 1,0,1,0);
    tbl[3]  = ex(fw(mkv(0,0,1,4'h3,0,1,0, 5'd8,5'd9,5'd10, 32'h88,32'h90,32'd0),
                    0,5'd9,32'h55, 1,5'd9,32'h99),
                 4'h3, 32'h88, 32'h99, 32'h99, 5'd10, 1,0,1,0);
    tbl[4]  = ex(fw(mkv(0,0,1,4'h3,1,1,0, 5'd3,5'd4,5'd5, 32'h30,32'h1,32'hFFFF_FFFC),
                    1,5'd4,32'd9, 0,5'd0,32'd0),
                 4'h3, 32'h30, 32'hFFFF_FFFC, 32'd9, 5'd5, 1,0,1,0);
    tbl[5]  = ex(mkv(0,0,0,4'h3,0,1,1, 5'd2,5'd3,5'd7, 32'h11,32'h22,32'd0),
                 4'h3, 32'h11, 32'h22, 32'h22, 5'd7, 0,0,0,0);
    tbl[6]  = ex(fw(mkv(1,0,1,4'h3,0,1,0, 5'd2,5'd3,5'd7, 32'h11,32'h22,32'd0),
                    1,5'd0,32'hDEAD, 1,5'd0,32'hBEEF),
                 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0,0,0);
    tbl[7]  = ex(fw(mkv(0,0,1,4'h2,0,1,0, 5'd0,5'd0,5'd1, 32'h33,32'h34,32'd0),
                    1,5'd0,32'h44, 0,5'd0,32'd0),
                 4'h2, 32'h33, 32'h34, 32'h34, 5'd1, 1,0,1,0);
    tbl[8]  = ex(mkv(0,0,1,4'h3,1,1,1, 5'd1,5'd4,5'd4, 32'h100,32'h77,32'd8),
                 4'h3, 32'h100, 32'd8, 32'h77, 5'd4, 1,1,1,0);
    tbl[9]  = ex(fw(mkv(0,0,1,4'h3,0,1,0, 5'd4,5'd5,5'd7, 32'h200,32'h300,32'd0),
                    0,5'd0,32'd0, 1,5'd4,32'h400),
                 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0,0,1);
    tbl[10] = ex(fw(mkv(0,0,1,4'h3,0,1,0, 5'd4,5'd5,5'd7, 32'h200,32'h300,32'd0),
                    0,5'd0,32'd0, 1,5'd4,32'h400),
                 4'h3, 32'h400, 32'h300, 32'h300, 5'd7, 1,0,1,0);
    tbl[11] = ex(fw(mkv(0,1,1,4'h2,0,0,0, 5'd9,5'd10,5'd11, 32'h999,32'h111,32'd0),
                    0,5'd0,32'd0, 1,5'd4,32'h400),
                 4'h3, 32'h400, 32'h300, 32'h300, 5'd7, 1,0,1,0);

    drive(mkv(0,0,0,4'h0,0,0,0, 5'd0,5'd0,5'd0, 32'd0,32'd0,32'd0));
    reset = 1'b0;
    #12;
    chk_zero("reset_init");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Hold for three cycles, then flush wins over stall.
    v = ex(mkv(0,0,1,4'h3,0,1,0, 5'd1,5'd2,5'd3, 32'd5,32'd7,32'd0),
           4'h3, 32'd5, 32'd7, 32'd7, 5'd3, 1,0,1,0);
    apply(v, "stall_load");
    for (int k = 0; k < 3; k++) begin
      v = ex(mkv(0,1,1,4'h2,1,0,1, 5'd6,5'd7,5'd8, 32'h66,32'h77,32'h5),
             4'h3, 32'd5, 32'd7, 32'd7, 5'd3, 1,0,1,0);
      apply(v, $sformatf("stall_hold%0d", k));
    end
    v = ex(mkv(1,1,1,4'h2,0,1,0, 5'd6,5'd7,5'd8, 32'h66,32'h77,32'h5),
           4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0,0,0);
    apply(v, "flush_stall");

    // Load-use bubble beats stall.
    v = ex(mkv(0,0,1,4'h3,1,1,1, 5'd1,5'd2,5'd4, 32'd1,32'd2,32'd4),
           4'h3, 32'd1, 32'd4, 32'd2, 5'd4, 1,1,1,0);
    apply(v, "lw_r4");
    v = ex(mkv(0,1,1,4'h3,0,1,0, 5'd4,5'd2,5'd9, 32'd1,32'd2,32'd0),
           4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0,0,1);
    apply(v, "hz_over_stall");

    // rt only hazards when used as operand B; r0 loads and invalid decode never hazard.
    v = ex(mkv(0,0,1,4'h3,0,1,1, 5'd1,5'd2,5'd5, 32'd1,32'd2,32'd0),
           4'h3, 32'd1, 32'd2, 32'd2, 5'd5, 1,1,1,0);
    apply(v, "lw_r5");
    v = ex(mkv(0,1,1,4'h3,1,1,0, 5'd1,5'd5,5'd9, 32'd3,32'd3,32'd3),
           4'h3, 32'd1, 32'd2, 32'd2, 5'd5, 1,1,1,0);
    apply(v, "rt_imm_nohz");
    v = ex(mkv(0,1,1,4'h3,0,1,0, 5'd1,5'd5,5'd9, 32'd3,32'd3,32'd3),
           4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0,0,0,1);
    apply(v, "rt_hz");
    v = ex(mkv(0,0,1,4'h3,1,1,1, 5'd0,5'd2,5'd0, 32'h50,32'd2,32'd1),
           4'h3, 32'h50, 32'd1, 32'd2, 5'd0, 1,1,1,0);
    apply(v, "lw_r0");
    v = ex(mkv(0,1,1,4'h3,0,1,0, 5'd0,5'd0,5'd9, 32'd3,32'd3,32'd3),
           4'h3, 32'h50, 32'd1, 32'd2, 5'd0, 1,1,1,0);
    apply(v, "r0_nohz");
    v = ex(mkv(0,0,1,4'h3,1,1,1, 5'd1,5'd2,5'd6, 32'd1,32'd2,32'd3),
           4'h3, 32'd1, 32'd3, 32'd2, 5'd6, 1,1,1,0);
    apply(v, "lw_r6");
    v = ex(mkv(0,1,0,4'h3,0,1,0, 5'd6,5'd6,5'd9, 32'd3,32'd3,32'd3),
           4'h3, 32'd1, 32'd3, 32'd2, 5'd6, 1,1,1,0);
    apply(v, "invalid_nohz");

    // Asynchronous reset mid-stream clears outputs without waiting for an edge.
    chk("pre_reset.valid", {31'b0, valid_o}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("reset_async");
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
